trim_ctx_sched: RTL and testbench

Context scheduler for the `trim` crop/subsample/reverse datapath. It queues ROI contexts programmed by the host and applies exactly one context per frame, only between frames. It snoops the AXI-stream handshake at `trim`'s input to find frame boundaries, drives `trim`'s static configuration and `aclk_load_context`/`aclk_grab_queue_en`, and reports frame, miss and error status.

---
 rtl/trim_ctx_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_trim_ctx_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_ctx_sched.sv
// Context scheduler for trim: queues host ROI contexts and applies exactly one per
// frame, only between frames, by snooping the stream handshake at trim's input.
module trim_ctx_sched #(
    parameter int QUEUE_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 aclk_reset_n,
    input  logic                 host_push,
    input  logic [2:0]           host_pixel_width,
    input  logic                 host_x_crop_en,
    input  logic [12:0]          host_x_start,
    input  logic [12:0]          host_x_size,
    input  logic [3:0]           host_x_scale,
    input  logic                 host_x_reverse,
    input  logic                 host_y_roi_en,
    input  logic [12:0]          host_y_start,
    input  logic [12:0]          host_y_size,
    input  logic                 host_flush,
    input  logic                 host_clr_err,
    input  logic                 snoop_tvalid,
    input  logic                 snoop_tready,
    input  logic                 snoop_tlast,
    input  logic [3:0]           snoop_tuser,
    output logic [2:0]           aclk_pixel_width,
    output logic                 aclk_x_crop_en,
    output logic [12:0]          aclk_x_start,
    output logic [12:0]          aclk_x_size,
    output logic [3:0]           aclk_x_scale,
    output logic                 aclk_x_reverse,
    output logic                 aclk_y_roi_en,
    output logic [12:0]          aclk_y_start,
    output logic [12:0]          aclk_y_size,
    output logic [1:0]           aclk_load_context,
    output logic                 aclk_grab_queue_en,
    output logic [2:0]           queue_level,
    output logic                 queue_full,
    output logic                 frame_active,
    output logic [12:0]          line_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic                 err_overrun,
    output logic                 err_sync
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [12:0] LINE_MAX = '1;

    typedef struct packed {
        logic [2:0]  pixel_width;
        logic        x_crop_en;
        logic [12:0] x_start;
        logic [12:0] x_size;
        logic [3:0]  x_scale;
        logic        x_reverse;
        logic        y_roi_en;
        logic [12:0] y_start;
        logic [12:0] y_size;
    } ctx_t;

    typedef enum logic [1:0] {IDLE, ARMED, FRAME, SKIP} state_t;

    state_t                 state_reg, state_next;
    ctx_t                   slot_reg [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [2:0]             level_reg, level_next;
    ctx_t                   staged_reg;
    logic                   staged_valid_reg;
    ctx_t                   cfg_reg;
    logic                   load_reg, parity_reg;
    logic                   grab_reg, full_reg, active_reg;
    logic [12:0]            line_reg;
    logic [CNT_WIDTH-1:0]   frame_cnt_reg, miss_cnt_reg;
    logic                   err_overrun_reg, err_sync_reg;

    ctx_t host_ctx, head_ctx;
    logic beat, sof_beat, eof_beat, line_end, has_pending;
    logic pop, stage, load_staged, load_head;
    logic miss_inc, frame_inc, sync_err, line_clear, line_inc;
    logic accept, overrun_ev;
    logic unused_sync;

    assign host_ctx = {host_pixel_width, host_x_crop_en, host_x_start, host_x_size,
                       host_x_scale, host_x_reverse, host_y_roi_en, host_y_start,
                       host_y_size};
    assign head_ctx    = slot_reg[rd_ptr_reg];
    assign has_pending = (level_reg != 3'd0);

    assign beat        = snoop_tvalid & snoop_tready;
    assign sof_beat    = beat & snoop_tuser[0];
    assign eof_beat    = beat & snoop_tlast & snoop_tuser[1];
    assign line_end    = beat & snoop_tlast;
    // SOL/EOL are not needed: tlast alone marks the line end.
    assign unused_sync = ^snoop_tuser[3:2];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        stage       = 1'b0;
        load_staged = 1'b0;
        load_head   = 1'b0;
        miss_inc    = 1'b0;
        frame_inc   = 1'b0;
        sync_err    = 1'b0;
        line_clear  = 1'b0;
        line_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sof_beat) begin
                    // A context popped alongside a missed SOF is held back and
                    // applied at the next IDLE rather than mid-frame.
                    miss_inc = 1'b1;
                    if (!host_flush && !staged_valid_reg && has_pending) begin
                        pop   = 1'b1;
                        stage = 1'b1;
                    end
                    state_next = eof_beat ? IDLE : SKIP;
                end else if (!host_flush && staged_valid_reg) begin
                    load_staged = 1'b1;
                    state_next  = ARMED;
                end else if (!host_flush && has_pending) begin
                    pop        = 1'b1;
                    load_head  = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (sof_beat) begin
                    line_clear = 1'b1;
                    if (eof_beat) begin
                        frame_inc  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = FRAME;
                    end
                end
            end
            FRAME: begin
                if (sof_beat) begin
                    sync_err   = 1'b1;
                    line_clear = 1'b1;
                end else if (line_end) begin
                    line_inc = 1'b1;
                end
                if (eof_beat) begin
                    frame_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
            SKIP: begin
                if (eof_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a push into a full queue still lands.
    always_comb begin
        accept     = host_push && !host_flush && ((level_reg != 3'(QUEUE_DEPTH)) || pop);
        overrun_ev = host_push && !host_flush && !accept;
        if (host_flush) level_next = 3'd0;
        else            level_next = level_reg + {2'b00, accept} - {2'b00, pop};
    end

    always_ff @(posedge aclk) begin
        if (accept) slot_reg[wr_ptr_reg] <= host_ctx;
    end

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            state_reg        <= IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            staged_reg       <= '0;
            staged_valid_reg <= 1'b0;
            cfg_reg          <= '0;
            load_reg         <= 1'b0;
            parity_reg       <= 1'b0;
            grab_reg         <= 1'b0;
            full_reg         <= 1'b0;
            active_reg       <= 1'b0;
            line_reg         <= '0;
            frame_cnt_reg    <= '0;
            miss_cnt_reg     <= '0;
            err_overrun_reg  <= 1'b0;
            err_sync_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            level_reg  <= level_next;
            full_reg   <= (level_next == 3'(QUEUE_DEPTH));
            grab_reg   <= (state_next == ARMED) || (state_next == FRAME);
            active_reg <= (state_next == FRAME);

            if (host_flush) begin
                wr_ptr_reg       <= '0;
                rd_ptr_reg       <= '0;
                staged_valid_reg <= 1'b0;
            end else begin
                if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (pop)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                if (stage) begin
                    staged_reg       <= head_ctx;
                    staged_valid_reg <= 1'b1;
                end else if (load_staged) begin
                    staged_valid_reg <= 1'b0;
                end
            end

            load_reg <= load_staged | load_head;
            if (load_staged)    cfg_reg <= staged_reg;
            else if (load_head) cfg_reg <= head_ctx;
            if (load_staged || load_head) parity_reg <= ~parity_reg;

            if (line_clear)
                line_reg <= {12'd0, line_end};
            else if (line_inc && line_reg != LINE_MAX)
                line_reg <= line_reg + 13'd1;

            if (frame_inc && frame_cnt_reg != '1) frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (miss_inc && miss_cnt_reg != '1)   miss_cnt_reg  <= miss_cnt_reg + 1'b1;

            if (overrun_ev)        err_overrun_reg <= 1'b1;
            else if (host_clr_err) err_overrun_reg <= 1'b0;
            if (sync_err)          err_sync_reg    <= 1'b1;
            else if (host_clr_err) err_sync_reg    <= 1'b0;
        end
    end

    assign aclk_pixel_width   = cfg_reg.pixel_width;
    assign aclk_x_crop_en     = cfg_reg.x_crop_en;
    assign aclk_x_start       = cfg_reg.x_start;
    assign aclk_x_size        = cfg_reg.x_size;
    assign aclk_x_scale       = cfg_reg.x_scale;
    assign aclk_x_reverse     = cfg_reg.x_reverse;
    assign aclk_y_roi_en      = cfg_reg.y_roi_en;
    assign aclk_y_start       = cfg_reg.y_start;
    assign aclk_y_size        = cfg_reg.y_size;
    assign aclk_load_context  = {parity_reg, load_reg};
    assign aclk_grab_queue_en = grab_reg;
    assign queue_level        = level_reg;
    assign queue_full         = full_reg;
    assign frame_active       = active_reg;
    assign line_cnt           = line_reg;
    assign frame_cnt          = frame_cnt_reg;
    assign miss_cnt           = miss_cnt_reg;
    assign err_overrun        = err_overrun_reg;
    assign err_sync           = err_sync_reg;

endmodule

// File: tb/tb_trim_ctx_sched.sv
// Randomised bench for trim_ctx_sched: a transaction-level reference model predicts
// loads and status, a negedge monitor pops and compares against the DUT.
module tb_trim_ctx_sched;
    localparam int DEPTH = 2;
    localparam int M_IDLE = 0, M_ARMED = 1, M_FRAME = 2, M_SKIP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        host_push = 1'b0, host_flush = 1'b0, host_clr_err = 1'b0;
    logic [61:0] hvec = '0;
    logic        tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
    logic [3:0]  tuser = '0;

    logic [2:0]  o_pw;
    logic        o_crop, o_rev, o_yroi;
    logic [12:0] o_xs, o_xsz, o_ys, o_ysz;
    logic [3:0]  o_scale;
    logic [1:0]  load_ctx;
    logic        grab, queue_full, frame_active, err_overrun, err_sync;
    logic [2:0]  queue_level;
    logic [12:0] line_cnt;
    logic [15:0] frame_cnt, miss_cnt;
    logic [61:0] cfg_out;

    assign cfg_out = {o_pw, o_crop, o_xs, o_xsz, o_scale, o_rev, o_yroi, o_ys, o_ysz};

    trim_ctx_sched #(.QUEUE_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .aclk(clk), .aclk_reset_n(rst_n), .host_push(host_push),
        .host_pixel_width(hvec[61:59]), .host_x_crop_en(hvec[58]),
        .host_x_start(hvec[57:45]), .host_x_size(hvec[44:32]),
        .host_x_scale(hvec[31:28]), .host_x_reverse(hvec[27]),
        .host_y_roi_en(hvec[26]), .host_y_start(hvec[25:13]), .host_y_size(hvec[12:0]),
        .host_flush(host_flush), .host_clr_err(host_clr_err),
        .snoop_tvalid(tvalid), .snoop_tready(tready), .snoop_tlast(tlast), .snoop_tuser(tuser),
        .aclk_pixel_width(o_pw), .aclk_x_crop_en(o_crop), .aclk_x_start(o_xs),
        .aclk_x_size(o_xsz), .aclk_x_scale(o_scale), .aclk_x_reverse(o_rev),
        .aclk_y_roi_en(o_yroi), .aclk_y_start(o_ys), .aclk_y_size(o_ysz),
        .aclk_load_context(load_ctx), .aclk_grab_queue_en(grab),
        .queue_level(queue_level), .queue_full(queue_full), .frame_active(frame_active),
        .line_cnt(line_cnt), .frame_cnt(frame_cnt), .miss_cnt(miss_cnt),
        .err_overrun(err_overrun), .err_sync(err_sync)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, in terms of pending contexts and frame phase.
    int          mode = M_IDLE;
    logic [61:0] pend[$];
    bit          staged = 0;
    logic [61:0] staged_ctx = '0;
    logic [61:0] m_cfg = '0;
    bit          m_par = 0;
    int          m_frames = 0, m_miss = 0, m_line = 0;
    bit          m_eov = 0, m_esync = 0;
    logic [62:0] exp_load[$];
    bit          b_sof, b_eof, b_le, ev_ov, ev_sync;

    task automatic apply_ctx(input logic [61:0] c);
        m_cfg = c;
        m_par = ~m_par;
        exp_load.push_back({c, m_par});
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mode = M_IDLE; pend.delete(); staged = 0; m_cfg = '0; m_par = 0;
            m_frames = 0; m_miss = 0; m_line = 0; m_eov = 0; m_esync = 0;
            exp_load.delete();
        end else begin
            b_sof = tvalid && tready && tuser[0];
            b_eof = tvalid && tready && tlast && tuser[1];
            b_le  = tvalid && tready && tlast;
            ev_ov = 0; ev_sync = 0;
            case (mode)
                M_IDLE: begin
                    if (b_sof) begin
                        m_miss = (m_miss == 65535) ? m_miss : m_miss + 1;
                        if (!host_flush && !staged && pend.size() > 0) begin
                            staged_ctx = pend.pop_front();
                            staged = 1;
                        end
                        mode = b_eof ? M_IDLE : M_SKIP;
                    end else if (!host_flush && staged) begin
                        apply_ctx(staged_ctx);
                        staged = 0;
                        mode = M_ARMED;
                    end else if (!host_flush && pend.size() > 0) begin
                        apply_ctx(pend.pop_front());
                        mode = M_ARMED;
                    end
                end
                M_ARMED: begin
                    if (b_sof) begin
                        m_line = b_le ? 1 : 0;
                        if (b_eof) begin
                            m_frames = (m_frames == 65535) ? m_frames : m_frames + 1;
                            mode = M_IDLE;
                        end else begin
                            mode = M_FRAME;
                        end
                    end
                end
                M_FRAME: begin
                    if (b_sof) begin
                        ev_sync = 1;
                        m_line = b_le ? 1 : 0;
                    end else if (b_le && m_line < 8191) begin
                        m_line = m_line + 1;
                    end
                    if (b_eof) begin
                        m_frames = (m_frames == 65535) ? m_frames : m_frames + 1;
                        mode = M_IDLE;
                    end
                end
                default: if (b_eof) mode = M_IDLE;
            endcase
            if (host_flush) begin
                pend.delete();
                staged = 0;
            end else if (host_push) begin
                if (pend.size() < DEPTH) pend.push_back(hvec);
                else ev_ov = 1;
            end
            m_eov   = ev_ov   ? 1'b1 : (host_clr_err ? 1'b0 : m_eov);
            m_esync = ev_sync ? 1'b1 : (host_clr_err ? 1'b0 : m_esync);
        end
    end

    logic [62:0] e_load;
    initial forever begin
        @(negedge clk);
        chk("load_pulse", load_ctx[0], exp_load.size() != 0);
        if (load_ctx[0] && exp_load.size() != 0) begin
            e_load = exp_load.pop_front();
            chk("load_ctx", {cfg_out, load_ctx[1]}, e_load);
        end
        exp_load.delete();
        chk("queue_level", queue_level, pend.size());
        chk("queue_full", queue_full, pend.size() == DEPTH);
        chk("frame_active", frame_active, mode == M_FRAME);
        chk("grab_queue_en", grab, (mode == M_ARMED) || (mode == M_FRAME));
        chk("line_cnt", line_cnt, m_line);
        chk("frame_cnt", frame_cnt, m_frames);
        chk("miss_cnt", miss_cnt, m_miss);
        chk("err_overrun", err_overrun, m_eov);
        chk("err_sync", err_sync, m_esync);
        chk("config", cfg_out, m_cfg);
        chk("parity", load_ctx[1], m_par);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [61:0] mk_ctx(input logic [12:0] xs, input logic [12:0] xsz,
                                           input logic [3:0] sc);
        return {3'd0, 1'b1, xs, xsz, sc, 1'b0, 1'b0, 13'd0, 13'd0};
    endfunction

    function automatic logic [61:0] rnd_ctx();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[61:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic host_op(input bit push, input bit flush, input bit clr, input logic [61:0] c);
        host_push = push; host_flush = flush; host_clr_err = clr; hvec = c;
        @(posedge clk); #1;
        host_push = 1'b0; host_flush = 1'b0; host_clr_err = 1'b0;
    endtask

    // One handshake beat, optionally preceded by stall cycles carrying junk sideband.
    task automatic sbeat(input bit sof, input bit eof, input bit last, input bit sol);
        int st, k;
        st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        for (int i = 0; i < st; i++) begin
            k = $urandom_range(0, 2);
            tvalid = (k == 1); tready = (k == 2);
            tlast = 1'($urandom_range(0, 1)); tuser = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        tvalid = 1'b1; tready = 1'b1; tlast = last; tuser = {last, sol, eof, sof};
        @(posedge clk); #1;
        tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tuser = 4'd0;
    endtask

    task automatic send_frame(input int lines, input int bpl, input int sof_line, input int rst_line);
        bit last;
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < bpl; b++) begin
                last = (b == bpl - 1);
                sbeat((b == 0) && (l == 0 || l == sof_line), last && (l == lines - 1), last, b == 0);
            end
            if (l == rst_line) begin
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        end
    endtask

    logic [61:0] ca, cb, cc;
    int r;

    initial begin
        ca = mk_ctx(13'd0, 13'd128, 4'd0);
        cb = mk_ctx(13'd16, 13'd64, 4'd1);
        cc = mk_ctx(13'd8, 13'd200, 4'd2);
        do_reset();
        @(negedge clk);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_config", cfg_out, 0);

        // single context, 5-line frame
        host_op(1, 0, 0, ca);
        @(negedge clk); chk("s1_load_early", load_ctx[0], 0);
        @(negedge clk); chk("s1_load_pulse", load_ctx[0], 1);
        idle(2);
        send_frame(5, 32, -1, -1);
        @(negedge clk);
        chk("s1_frame_cnt", frame_cnt, 1);
        chk("s1_line_cnt", line_cnt, 5);
        chk("s1_parity", load_ctx[1], 1);
        chk("s1_x_size", o_xsz, 128);

        // two contexts, three frames: the last one is missed
        do_reset();
        host_op(1, 0, 0, ca);
        host_op(1, 0, 0, cb);
        idle(3);
        for (int f = 0; f < 3; f++) begin
            send_frame(3, 8, -1, -1);
            idle(4);
        end
        @(negedge clk);
        chk("s2_frame_cnt", frame_cnt, 2);
        chk("s2_miss_cnt", miss_cnt, 1);
        chk("s2_config_b", cfg_out, cb);
        chk("s2_idle", grab, 0);

        // overrun while a frame is active
        do_reset();
        host_op(1, 0, 0, ca);
        idle(3);
        fork
            send_frame(3, 16, -1, -1);
            begin
                idle(6);
                host_op(1, 0, 0, cb);
                host_op(1, 0, 0, cc);
                host_op(1, 0, 0, ca);
                @(negedge clk);
                chk("s3_level", queue_level, 2);
                chk("s3_full", queue_full, 1);
                chk("s3_overrun", err_overrun, 1);
                chk("s3_active", frame_active, 1);
                host_op(0, 0, 1, '0);
                @(negedge clk);
                chk("s3_overrun_clr", err_overrun, 0);
            end
        join
        idle(3);
        host_op(1, 1, 0, cc);
        @(negedge clk);
        chk("s3_flush_level", queue_level, 0);

        // new context pushed mid-frame reloads only after EOF
        do_reset();
        host_op(1, 0, 0, ca);
        idle(3);
        fork
            send_frame(3, 8, -1, -1);
            begin idle(5); host_op(1, 0, 0, cc); end
        join
        @(negedge clk);
        chk("s4_cfg_hold", cfg_out, ca);
        chk("s4_no_load", load_ctx[0], 0);
        @(negedge clk);
        chk("s4_reload", load_ctx[0], 1);
        chk("s4_cfg_new", cfg_out, cc);

        // second SOF mid-frame
        do_reset();
        host_op(1, 0, 0, ca);
        idle(3);
        send_frame(4, 4, 2, -1);
        @(negedge clk);
        chk("s5_err_sync", err_sync, 1);
        chk("s5_line_cnt", line_cnt, 2);
        chk("s5_frame_cnt", frame_cnt, 1);

        // reset after line 2; the frame tail must be ignored
        do_reset();
        host_op(1, 0, 0, ca);
        idle(3);
        send_frame(4, 8, -1, 1);
        @(negedge clk);
        chk("s6_frame_cnt", frame_cnt, 0);
        chk("s6_parity", load_ctx[1], 0);
        chk("s6_level", queue_level, 0);
        host_op(1, 0, 0, cb);
        idle(3);
        send_frame(2, 4, -1, -1);
        @(negedge clk);
        chk("s6_frame_after", frame_cnt, 1);
        chk("s6_config", cfg_out, cb);

        // randomised traffic with concurrent host activity
        do_reset();
        for (int it = 0; it < 60; it++) begin
            fork
                begin
                    idle($urandom_range(0, 3));
                    if ($urandom_range(0, 7) != 0)
                        send_frame($urandom_range(1, 4), $urandom_range(1, 4),
                                   ($urandom_range(0, 5) == 0) ? 1 : -1, -1);
                end
                begin
                    repeat ($urandom_range(0, 4)) begin
                        idle($urandom_range(0, 3));
                        r = $urandom_range(0, 9);
                        if (r < 6)       host_op(1, 0, 0, rnd_ctx());
                        else if (r == 6) host_op(0, 1, 0, '0);
                        else if (r == 7) host_op(1, 1, 0, rnd_ctx());
                        else if (r == 8) host_op(0, 0, 1, '0);
                        else             host_op(1, 0, 1, rnd_ctx());
                    end
                end
            join
        end
        idle(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
